display_type_gen: RTL and testbench

//  Per-pixel layer selector feeding color_mapper: picks display_type (8b code) and sprite ROM address from

---
 rtl/display_type_gen_if.sv | 38 +++
 rtl/display_type_gen.sv | 171 +++++++++++++++++
 tb/tb_display_type_gen.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/display_type_gen_if.sv
// Pixel-pipeline bus for display_type_gen: frame/pixel timing, screen requests,
// object positions in, sprite ROM address and layer code out.
interface display_type_gen_if #(
  parameter int N_MON = 4,
  parameter int N_TWR = 4,
  parameter int SPR   = 32
);
  localparam int AW = 2 * $clog2(SPR);

  logic                  frame_start;
  logic [9:0]            DrawX;
  logic [9:0]            DrawY;
  logic                  is_open;
  logic                  is_game;
  logic                  is_vict;
  logic                  is_fail;
  logic [10*N_MON-1:0]   mon_x;
  logic [10*N_MON-1:0]   mon_y;
  logic [2*N_MON-1:0]    mon_type;
  logic [10*N_TWR-1:0]   twr_x;
  logic [10*N_TWR-1:0]   twr_y;
  logic [N_TWR-1:0]      twr_en;
  logic [4:0]            hp;
  logic [AW-1:0]         sprite_addr;
  logic [7:0]            display_type;

  modport master (
    output frame_start, DrawX, DrawY, is_open, is_game, is_vict, is_fail,
    output mon_x, mon_y, mon_type, twr_x, twr_y, twr_en, hp,
    input  sprite_addr, display_type
  );

  modport slave (
    input  frame_start, DrawX, DrawY, is_open, is_game, is_vict, is_fail,
    input  mon_x, mon_y, mon_type, twr_x, twr_y, twr_en, hp,
    output sprite_addr, display_type
  );
endinterface

// File: rtl/display_type_gen.sv
// Per-pixel layer selector: screen FSM and object shadows latched per frame,
// stage 1 hit-tests and emits sprite ROM address, stage 2 emits the layer code.
module display_type_gen #(
  parameter int N_MON  = 4,
  parameter int N_TWR  = 4,
  parameter int SPR    = 32,
  parameter int HP_MAX = 20
) (
  input logic              Clk,
  input logic              Reset,
  display_type_gen_if.slave bus
);
  localparam int SW = $clog2(SPR);
  localparam int AW = 2 * SW;

  typedef enum logic [1:0] {S_OPEN, S_GAME, S_VICT, S_FAIL} state_e;

  state_e               state_q, state_d;
  logic [5:0]           frame_cnt_q, frame_cnt_d;
  logic [10*N_MON-1:0]  mon_x_q, mon_y_q;
  logic [2*N_MON-1:0]   mon_type_q;
  logic [10*N_TWR-1:0]  twr_x_q, twr_y_q;
  logic [N_TWR-1:0]     twr_en_q;
  logic [4:0]           hp_q;
  logic [AW-1:0]        addr_q, addr_d;
  logic [7:0]           code1_q, code_d;
  logic [7:0]           code2_q;

  logic [10:0]          px, py;
  logic                 boss_found, mon_found, twr_found;
  logic [AW-1:0]        boss_addr, mon_addr, twr_addr;
  logic [7:0]           mon_code;
  logic                 in_bar, in_box;

  assign px = {1'b0, bus.DrawX};
  assign py = {1'b0, bus.DrawY};

  // 11-bit compare so a sprite near the right/bottom edge clips instead of wrapping
  function automatic logic hit_f(input logic [9:0] ox, input logic [9:0] oy,
                                 input logic [10:0] cx, input logic [10:0] cy);
    return (cx >= {1'b0, ox}) && (cx < {1'b0, ox} + 11'(SPR)) &&
           (cy >= {1'b0, oy}) && (cy < {1'b0, oy} + 11'(SPR));
  endfunction

  function automatic logic [AW-1:0] addr_f(input logic [9:0] ox, input logic [9:0] oy,
                                           input logic [10:0] cx, input logic [10:0] cy);
    logic [20:0] a;
    a = 21'(cy - {1'b0, oy}) * 21'(SPR) + 21'(cx - {1'b0, ox});
    return a[AW-1:0];
  endfunction

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    if (bus.frame_start) begin
      if (bus.is_fail)      state_d = S_FAIL;
      else if (bus.is_vict) state_d = S_VICT;
      else if (bus.is_game) state_d = S_GAME;
      else if (bus.is_open) state_d = S_OPEN;
      frame_cnt_d = (state_d != state_q) ? 6'd0 : frame_cnt_q + 6'd1;
    end
  end

  // Boss hits outrank ordinary monsters regardless of slot; lowest slot wins within each class
  always_comb begin
    boss_found = 1'b0;
    mon_found  = 1'b0;
    twr_found  = 1'b0;
    boss_addr  = '0;
    mon_addr   = '0;
    twr_addr   = '0;
    mon_code   = 8'h00;
    for (int unsigned i = 0; i < N_MON; i++) begin
      if (mon_type_q[2*i +: 2] != 2'd0 &&
          hit_f(mon_x_q[10*i +: 10], mon_y_q[10*i +: 10], px, py)) begin
        if (mon_type_q[2*i +: 2] == 2'd3) begin
          if (!boss_found) begin
            boss_found = 1'b1;
            boss_addr  = addr_f(mon_x_q[10*i +: 10], mon_y_q[10*i +: 10], px, py);
          end
        end else if (!mon_found) begin
          mon_found = 1'b1;
          mon_addr  = addr_f(mon_x_q[10*i +: 10], mon_y_q[10*i +: 10], px, py);
          mon_code  = (mon_type_q[2*i +: 2] == 2'd1) ? 8'h04 : 8'h05;
        end
      end
    end
    for (int unsigned j = 0; j < N_TWR; j++) begin
      if (!twr_found && twr_en_q[j] &&
          hit_f(twr_x_q[10*j +: 10], twr_y_q[10*j +: 10], px, py)) begin
        twr_found = 1'b1;
        twr_addr  = addr_f(twr_x_q[10*j +: 10], twr_y_q[10*j +: 10], px, py);
      end
    end
  end

  assign in_bar = (px >= 11'd8) && (px < 11'(8 + HP_MAX * 4)) &&
                  (py >= 11'd8) && (py < 11'd16);
  assign in_box = (px >= 11'd192) && (px <= 11'd447) &&
                  (py >= 11'd176) && (py <= 11'd303);

  always_comb begin
    code_d = 8'h00;
    addr_d = '0;
    unique case (state_q)
      S_OPEN: code_d = 8'h01;
      S_FAIL: code_d = frame_cnt_q[5] ? 8'h21 : 8'h20;
      S_VICT: begin
        if (in_box) begin
          code_d = 8'h35;
          addr_d = addr_f(10'd192, 10'd176, px, py);
        end else begin
          code_d = frame_cnt_q[5] ? 8'h36 : 8'h00;
        end
      end
      S_GAME: begin
        if (in_bar) begin
          if ((px - 11'd8) < 11'({hp_q, 2'b00}))
            code_d = (hp_q > 5'(HP_MAX / 4)) ? 8'h32 : 8'h30;
          else
            code_d = 8'h34;
        end else if (boss_found) begin
          code_d = 8'h0f;
          addr_d = boss_addr;
        end else if (mon_found) begin
          code_d = mon_code;
          addr_d = mon_addr;
        end else if (twr_found) begin
          code_d = 8'h10;
          addr_d = twr_addr;
        end
      end
      default: code_d = 8'h00;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_OPEN;
      frame_cnt_q <= '0;
      mon_x_q     <= '0;
      mon_y_q     <= '0;
      mon_type_q  <= '0;
      twr_x_q     <= '0;
      twr_y_q     <= '0;
      twr_en_q    <= '0;
      hp_q        <= '0;
      addr_q      <= '0;
      code1_q     <= '0;
      code2_q     <= '0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      if (bus.frame_start) begin
        mon_x_q    <= bus.mon_x;
        mon_y_q    <= bus.mon_y;
        mon_type_q <= bus.mon_type;
        twr_x_q    <= bus.twr_x;
        twr_y_q    <= bus.twr_y;
        twr_en_q   <= bus.twr_en;
        hp_q       <= (bus.hp > 5'(HP_MAX)) ? 5'(HP_MAX) : bus.hp;
      end
      addr_q  <= addr_d;
      code1_q <= code_d;
      code2_q <= code1_q;
    end
  end

  assign bus.sprite_addr  = addr_q;
  assign bus.display_type = code2_q;
endmodule

// File: tb/tb_display_type_gen.sv
// Directed bench for display_type_gen: hand-computed sprite addresses and layer
// codes checked at latency 1 and 2 after each probed pixel.
module tb_display_type_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  display_type_gen_if #(.N_MON(4), .N_TWR(4), .SPR(32)) bus ();

  display_type_gen #(.N_MON(4), .N_TWR(4), .SPR(32), .HP_MAX(20)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic probe(input string tag, input logic [9:0] x, input logic [9:0] y,
                       input int exp_addr, input logic [7:0] exp_code);
    @(negedge clk);
    bus.DrawX = x;
    bus.DrawY = y;
    @(posedge clk); #1;
    check_eq({tag, "/addr"}, 32'(bus.sprite_addr), exp_addr);
    @(posedge clk); #1;
    check_eq({tag, "/code"}, 32'(bus.display_type), 32'(exp_code));
  endtask

  task automatic pulse_frame();
    @(negedge clk);
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
  endtask

  task automatic set_mon(input int i, input int x, input int y, input int t);
    bus.mon_x[10*i +: 10]  = 10'(x);
    bus.mon_y[10*i +: 10]  = 10'(y);
    bus.mon_type[2*i +: 2] = 2'(t);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst/addr", 32'(bus.sprite_addr), 0);
    check_eq("rst/code", 32'(bus.display_type), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.frame_start = 1'b0;
    bus.DrawX = 10'd300; bus.DrawY = 10'd200;
    bus.is_open = 1'b0; bus.is_game = 1'b0; bus.is_vict = 1'b0; bus.is_fail = 1'b0;
    bus.mon_x = '0; bus.mon_y = '0; bus.mon_type = '0;
    bus.twr_x = '0; bus.twr_y = '0; bus.twr_en = '0;
    bus.hp = 5'd10;

    do_reset();
    probe("open", 10'd5, 10'd5, 0, 8'h01);

    // Single monster, interior, edges and clipping
    bus.is_game = 1'b1;
    set_mon(0, 100, 50, 1);
    pulse_frame();
    probe("mon_mid",   10'd110, 10'd60, 330,  8'h04);
    probe("mon_left",  10'd99,  10'd60, 0,    8'h00);
    probe("mon_last",  10'd131, 10'd81, 1023, 8'h04);
    probe("mon_right", 10'd132, 10'd60, 0,    8'h00);

    // Position change without frame_start must not show until the next pulse
    set_mon(0, 300, 50, 1);
    probe("hold_old", 10'd110, 10'd60, 330, 8'h04);
    pulse_frame();
    probe("moved_old", 10'd110, 10'd60, 0,   8'h00);
    probe("moved_new", 10'd310, 10'd60, 330, 8'h04);

    // Boss beats lower-slot monster and tower
    set_mon(0, 190, 190, 1);
    set_mon(2, 180, 180, 3);
    bus.twr_x[9:0] = 10'd195; bus.twr_y[9:0] = 10'd195; bus.twr_en[0] = 1'b1;
    pulse_frame();
    probe("boss", 10'd200, 10'd200, 660, 8'h0f);
    set_mon(2, 180, 180, 0);
    pulse_frame();
    probe("mon_over_twr", 10'd200, 10'd200, 330, 8'h04);
    set_mon(0, 190, 190, 0);
    pulse_frame();
    probe("tower", 10'd200, 10'd200, 165, 8'h10);

    // Health bar
    set_mon(0, 0, 0, 1);
    bus.hp = 5'd3;
    pulse_frame();
    probe("hp3_in",  10'd19, 10'd10, 0, 8'h30);
    probe("hp3_out", 10'd20, 10'd10, 0, 8'h34);
    bus.hp = 5'd10;
    pulse_frame();
    probe("hp10", 10'd19, 10'd10, 0, 8'h32);
    bus.hp = 5'd31;
    pulse_frame();
    probe("hp_sat_end",  10'd87, 10'd10, 0, 8'h32);
    probe("hp_sat_past", 10'd88, 10'd40, 0, 8'h00);
    bus.hp = 5'd5;
    pulse_frame();
    probe("hp5", 10'd8, 10'd8, 0, 8'h30);
    bus.hp = 5'd0;
    pulse_frame();
    probe("hp0", 10'd8, 10'd8, 0, 8'h34);
    set_mon(0, 0, 0, 0);

    // Victory screen
    bus.is_vict = 1'b1;
    pulse_frame();
    probe("vict_org", 10'd192, 10'd176, 0,   8'h35);
    probe("vict_end", 10'd447, 10'd303, 223, 8'h35);
    probe("vict_out", 10'd448, 10'd176, 0,   8'h00);

    // Pixel coincident with frame_start still sees the old (victory) state
    bus.is_vict = 1'b0;
    @(negedge clk);
    bus.frame_start = 1'b1;
    bus.DrawX = 10'd200; bus.DrawY = 10'd200;
    @(posedge clk); #1;
    check_eq("coinc/addr", 32'(bus.sprite_addr), 776);
    @(negedge clk);
    bus.frame_start = 1'b0;
    @(posedge clk); #1;
    check_eq("coinc/code", 32'(bus.display_type), 32'h35);
    @(posedge clk); #1;
    check_eq("coinc/next", 32'(bus.display_type), 32'h10);

    // Fail outranks victory; blink after 32 frames
    bus.is_fail = 1'b1;
    bus.is_vict = 1'b1;
    pulse_frame();
    probe("fail0", 10'd5, 10'd5, 0, 8'h20);
    repeat (31) pulse_frame();
    probe("fail31", 10'd5, 10'd5, 0, 8'h20);
    pulse_frame();
    probe("fail32", 10'd5, 10'd5, 0, 8'h21);

    // Mid-frame reset returns to the opening screen until the next pulse
    do_reset();
    probe("rst_open", 10'd200, 10'd200, 0, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
